// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and defaults for the fp_addsub request scheduler.
package fp_sched_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DONE
   } sched_state_t;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_FU_LAT  = 3;

   // Sized for the largest supported requester count (8).
   localparam int unsigned ID_W_MAX = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
   } tag_t;

endpackage

// File: rtl/fp_addsub_sched_if.sv
// Requester, functional-unit and response signals of the fp_addsub scheduler.
interface fp_addsub_sched_if
   import fp_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned BITWIDTH = 32
);
   localparam int unsigned IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ-1:0][BITWIDTH-1:0] req_a;
   logic [NUM_REQ-1:0][BITWIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]               req_sub;

   logic                fu_valid;
   logic                fu_sub;
   logic [BITWIDTH-1:0] fu_a;
   logic [BITWIDTH-1:0] fu_b;
   logic [BITWIDTH-1:0] fu_z;

   logic                resp_valid;
   logic [IDW-1:0]      resp_id;
   logic [BITWIDTH-1:0] resp_z;

   modport slave (
      input  req_valid, req_a, req_b, req_sub, fu_z,
      output req_ready, fu_valid, fu_sub, fu_a, fu_b, resp_valid, resp_id, resp_z
   );

   modport master (
      output req_valid, req_a, req_b, req_sub, fu_z,
      input  req_ready, fu_valid, fu_sub, fu_a, fu_b, resp_valid, resp_id, resp_z
   );

endinterface

// File: rtl/fp_addsub_sched_arb.sv
// Round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   always_comb begin
      logic [IDW-1:0] j;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = IDW'((32'(ptr) + k) % NUM_REQ);
         if (!any && req[j]) begin
            any      = 1'b1;
            idx      = j;
            grant[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one external fp_addsub unit among NUM_REQ requesters, with drain control.
module fp_addsub_sched
   import fp_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned FU_LAT   = DEF_FU_LAT,
   parameter int unsigned BITWIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   fp_addsub_sched_if.slave bus,
   input  logic             drain_req,
   output logic             drain_done
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = $clog2(FU_LAT + 3);

   sched_state_t       state, state_nxt;
   logic [IDW-1:0]     ptr, win_idx, issue_id;
   logic [NUM_REQ-1:0] grant;
   logic               any, xfer;
   logic [CW-1:0]      inflight, inflight_nxt;
   tag_t               tag_sr [FU_LAT];

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .any   (any)
   );

   assign xfer          = rst_n && (state == RUN) && any;
   assign bus.req_ready = xfer ? grant : '0;
   assign drain_done    = (state == DONE);

   // DRAIN exits on the post-edge count so DONE follows the last response directly.
   always_comb begin
      inflight_nxt = inflight;
      if (xfer && !bus.resp_valid)      inflight_nxt = inflight + CW'(1);
      else if (!xfer && bus.resp_valid) inflight_nxt = inflight - CW'(1);

      state_nxt = state;
      case (state)
         RUN:     if (drain_req) state_nxt = DRAIN;
         DRAIN:   if (!drain_req) state_nxt = RUN;
                  else if (inflight_nxt == '0) state_nxt = DONE;
         DONE:    if (!drain_req) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         ptr      <= '0;
         inflight <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= inflight_nxt;
         if (xfer) ptr <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.fu_valid   <= 1'b0;
         bus.fu_sub     <= 1'b0;
         bus.fu_a       <= '0;
         bus.fu_b       <= '0;
         issue_id       <= '0;
         for (int unsigned k = 0; k < FU_LAT; k++) tag_sr[k] <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_id    <= '0;
         bus.resp_z     <= '0;
      end else begin
         bus.fu_valid <= xfer;
         if (xfer) begin
            bus.fu_a   <= bus.req_a[win_idx];
            bus.fu_b   <= bus.req_b[win_idx];
            bus.fu_sub <= bus.req_sub[win_idx];
            issue_id   <= win_idx;
         end
         // Tag stage k tracks the unit stage holding the op issued k+1 cycles ago.
         tag_sr[0] <= '{valid: bus.fu_valid, id: ID_W_MAX'(issue_id)};
         for (int unsigned k = 1; k < FU_LAT; k++) tag_sr[k] <= tag_sr[k-1];
         bus.resp_valid <= tag_sr[FU_LAT-1].valid;
         if (tag_sr[FU_LAT-1].valid) begin
            bus.resp_id <= IDW'(tag_sr[FU_LAT-1].id);
            bus.resp_z  <= bus.fu_z;
         end
      end
   end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Directed bench for fp_addsub_sched with a fixed-latency unit stand-in.
module tb_fp_addsub_sched;
   import fp_sched_pkg::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned FL  = 3;
   localparam int unsigned BW  = 32;
   localparam int unsigned IDW = $clog2(NR);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic drain_req = 1'b0;
   logic drain_done;

   fp_addsub_sched_if #(.NUM_REQ(NR), .BITWIDTH(BW)) bus ();

   fp_addsub_sched #(.NUM_REQ(NR), .FU_LAT(FL), .BITWIDTH(BW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .drain_req  (drain_req),
      .drain_done (drain_done)
   );

   always #5 clk = ~clk;

   // Known IEEE cases return real sums; anything else is integer arithmetic.
   function automatic logic [31:0] fu_func(input logic [31:0] a, input logic [31:0] b, input logic s);
      if (a == 32'h3F800000 && b == 32'h40000000 && !s) return 32'h40400000;
      if (a == 32'h40400000 && b == 32'h3F800000 && s)  return 32'h40000000;
      return s ? a - b : a + b;
   endfunction

   logic [BW-1:0] fu_pipe [FL];
   always @(posedge clk) begin
      fu_pipe[0] <= fu_func(bus.fu_a, bus.fu_b, bus.fu_sub);
      for (int k = 1; k < FL; k++) fu_pipe[k] <= fu_pipe[k-1];
   end
   assign bus.fu_z = fu_pipe[FL-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [IDW-1:0] id; logic [BW-1:0] z; } resp_t;
   resp_t resp_q[$];
   always @(negedge clk)
      if (bus.resp_valid === 1'b1) resp_q.push_back('{cyc, bus.resp_id, bus.resp_z});

   typedef struct { int unsigned id; logic [BW-1:0] a; logic [BW-1:0] b; logic sub; logic [BW-1:0] z; } vec_t;
   vec_t vt [4];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int unsigned i, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic s);
      bus.req_a[i]   = a;
      bus.req_b[i]   = b;
      bus.req_sub[i] = s;
   endtask

   initial begin
      int t0;
      logic [NR-1:0] m;

      vt[0] = '{2, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
      vt[1] = '{0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
      vt[2] = '{3, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002};
      vt[3] = '{1, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030};

      bus.req_valid = '0;
      bus.req_sub   = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // Reset state
      #2 bus.req_valid = '1;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_fu_valid", 32'(bus.fu_valid), 0);
      chk("rst_fu_a", bus.fu_a, 0);
      chk("rst_fu_sub", 32'(bus.fu_sub), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_id", 32'(bus.resp_id), 0);
      chk("rst_resp_z", bus.resp_z, 0);
      chk("rst_drain_done", 32'(drain_done), 0);
      bus.req_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      step();

      // All four requesters continuously valid from ptr=0
      for (int i = 0; i < 4; i++) set_op(i, 32'h1000 + i, 32'h100, 1'b0);
      resp_q.delete();
      bus.req_valid = '1;
      t0 = 0;
      for (int k = 0; k < 8; k++) begin
         #1 chk("rr_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
         step();
         if (k == 0) t0 = cyc;
      end
      bus.req_valid = '0;
      repeat (FL + 3) step();
      chk("rr_nresp", resp_q.size(), 8);
      for (int k = 0; k < 8 && k < resp_q.size(); k++) begin
         chk("rr_resp_id", 32'(resp_q[k].id), k % 4);
         chk("rr_resp_z", resp_q[k].z, 32'h1100 + (k % 4));
         chk("rr_resp_cyc", resp_q[k].cyc, t0 + k + FL + 1);
      end

      // Single-op table
      for (int v = 0; v < 4; v++) begin
         set_op(vt[v].id, vt[v].a, vt[v].b, vt[v].sub);
         m = '0;
         m[vt[v].id] = 1'b1;
         bus.req_valid = m;
         #1 chk("vec_ready", 32'(bus.req_ready), 32'(m));
         step();
         bus.req_valid = '0;
         chk("vec_fu_valid", 32'(bus.fu_valid), 1);
         chk("vec_fu_a", bus.fu_a, vt[v].a);
         chk("vec_fu_b", bus.fu_b, vt[v].b);
         chk("vec_fu_sub", 32'(bus.fu_sub), 32'(vt[v].sub));
         for (int k = 1; k <= FL; k++) begin
            step();
            chk("vec_early_resp", 32'(bus.resp_valid), 0);
            if (k == 1) begin
               chk("vec_fu_idle", 32'(bus.fu_valid), 0);
               chk("vec_fu_a_hold", bus.fu_a, vt[v].a);
            end
         end
         step();
         chk("vec_resp_valid", 32'(bus.resp_valid), 1);
         chk("vec_resp_id", 32'(bus.resp_id), vt[v].id);
         chk("vec_resp_z", bus.resp_z, vt[v].z);
         step();
         chk("vec_resp_once", 32'(bus.resp_valid), 0);
         chk("vec_resp_z_hold", bus.resp_z, vt[v].z);
      end

      // Requesters 1 and 3 only, ptr now 2
      set_op(1, 32'h40, 32'h2, 1'b0);
      set_op(3, 32'h20, 32'h1, 1'b1);
      resp_q.delete();
      bus.req_valid = 4'b1010;
      #1 chk("p2_grant_first", 32'(bus.req_ready), 32'b1000);
      step();
      t0 = cyc;
      chk("p2_grant_second", 32'(bus.req_ready), 32'b0010);
      step();
      bus.req_valid = '0;
      repeat (FL + 3) step();
      chk("p2_nresp", resp_q.size(), 2);
      if (resp_q.size() == 2) begin
         chk("p2_id0", 32'(resp_q[0].id), 3);
         chk("p2_z0", resp_q[0].z, 32'h1F);
         chk("p2_cyc0", resp_q[0].cyc, t0 + FL + 1);
         chk("p2_id1", 32'(resp_q[1].id), 1);
         chk("p2_z1", resp_q[1].z, 32'h42);
         chk("p2_cyc1", resp_q[1].cyc, t0 + FL + 2);
      end
      drain_req = 1'b1;
      step();
      chk("p2_drain_enter", 32'(drain_done), 0);
      step();
      chk("p2_empty_done", 32'(drain_done), 1);
      drain_req = 1'b0;
      step();
      chk("p2_back_run", 32'(drain_done), 0);

      // Drain after three ops (ptr=2 -> grants 2,0,1)
      resp_q.delete();
      bus.req_valid = 4'b0111;
      #1 chk("dr_grant0", 32'(bus.req_ready), 32'b0100);
      step();
      chk("dr_grant1", 32'(bus.req_ready), 32'b0001);
      step();
      chk("dr_grant2", 32'(bus.req_ready), 32'b0010);
      step();
      t0 = cyc;
      bus.req_valid = '0;
      drain_req = 1'b1;
      step();
      bus.req_valid = '1;
      #1 chk("dr_ready_off", 32'(bus.req_ready), 0);
      for (int k = 0; k < FL + 3; k++) begin
         step();
         chk("dr_ready_held", 32'(bus.req_ready), 0);
         chk("dr_done", 32'(drain_done), 32'(cyc >= t0 + FL + 2));
      end
      chk("dr_nresp", resp_q.size(), 3);
      if (resp_q.size() == 3) begin
         chk("dr_id0", 32'(resp_q[0].id), 2);
         chk("dr_id1", 32'(resp_q[1].id), 0);
         chk("dr_id2", 32'(resp_q[2].id), 1);
      end

      // Leave DONE, then re-raise drain in the same cycle as a grant
      drain_req = 1'b0;
      bus.req_valid = 4'b1000;
      #1 chk("dn_ready_off", 32'(bus.req_ready), 0);
      step();
      chk("dn_left_done", 32'(drain_done), 0);
      drain_req = 1'b1;
      resp_q.delete();
      #1 chk("dn_same_cycle_grant", 32'(bus.req_ready), 32'b1000);
      step();
      bus.req_valid = '1;
      #1 chk("dn_drain_ready", 32'(bus.req_ready), 0);
      repeat (FL + 3) step();
      chk("dn_nresp", resp_q.size(), 1);
      if (resp_q.size() == 1) begin
         chk("dn_id", 32'(resp_q[0].id), 3);
         chk("dn_z", resp_q[0].z, 32'h1F);
      end
      chk("dn_done", 32'(drain_done), 1);
      drain_req = 1'b0;
      bus.req_valid = '0;
      step();

      // Reset with two ops in flight
      bus.req_valid = 4'b0011;
      step();
      step();
      bus.req_valid = '1;
      #2 rst_n = 1'b0;
      #1;
      chk("rs_fu_valid", 32'(bus.fu_valid), 0);
      chk("rs_fu_a", bus.fu_a, 0);
      chk("rs_fu_b", bus.fu_b, 0);
      chk("rs_ready", 32'(bus.req_ready), 0);
      chk("rs_resp_valid", 32'(bus.resp_valid), 0);
      resp_q.delete();
      bus.req_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      repeat (FL + 4) step();
      chk("rs_no_resp", resp_q.size(), 0);
      bus.req_valid = '1;
      #1 chk("rs_first_grant", 32'(bus.req_ready), 32'b0001);
      bus.req_valid = 4'b1110;
      #1 chk("rs_regrant", 32'(bus.req_ready), 32'b0010);
      bus.req_valid = '0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fp_addsub_sched.md
FP_ADDSUB_SCHED -- requirements
Module: fp_addsub_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one fp_addsub unit (2..8).
REQ-002 SHALL have parameter FU_LAT, default 3, cycles from fu_valid to fu_z valid (1..8).
REQ-003 SHALL have parameter BITWIDTH, default 32, operand/result width (IEEE single).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operation valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept.
REQ-008 SHALL have port req_a, req_b  input  NUM_REQ x BITWIDTH  per-requester operands.
REQ-009 SHALL have port req_sub  input  NUM_REQ  per-requester 1=subtract, 0=add.
REQ-010 SHALL have port fu_valid, fu_sub  output  1 each  issue strobe and op to unit.
REQ-011 SHALL have port fu_a, fu_b  output  BITWIDTH  operands to unit.
REQ-012 SHALL have port fu_z  input  BITWIDTH  unit result, valid FU_LAT cycles after issue.
REQ-013 SHALL have port resp_valid  output  1; resp_id  output  clog2(NUM_REQ); resp_z  output  BITWIDTH  returned result and owner.
REQ-014 SHALL have port drain_req  input  1 stop-issue request; drain_done  output  1 pipeline empty while draining.

Function
REQ-015 SHALL transfer a request when req_valid[i] && req_ready[i] at a rising edge; at most one transfer per cycle.
REQ-016 SHALL assert req_ready only for the round-robin winner, only in state RUN; ready may depend on req_valid (combinational grant).
REQ-017 Round-robin SHALL search from pointer ptr upward with wrap; after a transfer from i, ptr = (i+1) mod NUM_REQ; ptr unchanged without transfer.
REQ-018 SHALL register issue: transfer at edge E drives fu_valid=1, fu_a, fu_b, fu_sub during the cycle after E; fu_valid=0 otherwise; fu_a/fu_b/fu_sub hold last values when idle.
REQ-019 SHALL carry {valid, id} through a FU_LAT-deep tag shift register aligned with the unit pipeline.
REQ-020 SHALL register the response: resp_valid/resp_id/resp_z asserted exactly FU_LAT+1 cycles after the corresponding fu_valid cycle, one cycle wide; resp_z holds when resp_valid=0.
REQ-021 Responses SHALL have no backpressure and return in issue order; back-to-back issues yield back-to-back responses.
REQ-022 SHALL keep inflight counter (0..FU_LAT+2): +1 on transfer, -1 on resp_valid, both same cycle = unchanged.
REQ-023 FSM states RUN, DRAIN, DONE; RUN->DRAIN when drain_req=1; DRAIN->DONE when inflight=0; DONE->RUN when drain_req=0; DRAIN->RUN if drain_req drops before empty.
REQ-024 Transfer in the same cycle drain_req rises SHALL complete (ready computed from current state); no transfer in DRAIN or DONE.
REQ-025 drain_done SHALL be 1 only in DONE (registered state decode).
REQ-026 Requester lowering req_valid without transfer SHALL be legal; grant moves to next valid requester same cycle.

Reset
REQ-027 On rst_n=0 SHALL asynchronously clear: state=RUN, ptr=0, inflight=0, tag valids=0, fu_valid=0, fu_a=fu_b=0, fu_sub=0, resp_valid=0, resp_id=0, resp_z=0, drain_done=0.
REQ-028 Reset mid-operation SHALL discard all in-flight tags; no resp_valid for operations issued before reset.
REQ-029 req_ready SHALL be 0 while rst_n=0.

Structure
REQ-030 Package fp_sched_pkg SHALL hold the state enum (RUN, DRAIN, DONE), default NUM_REQ/FU_LAT constants and the tag struct {valid, id}.
REQ-031 Round-robin grant SHALL be sub-module rr_arbiter (inputs req vector, ptr; output one-hot grant, winner index, any).
REQ-032 The fp_addsub unit SHALL be external; the scheduler never instantiates it.

Verification
REQ-033 Single op: req_valid[2]=1, a=0x3F800000, b=0x40000000, sub=0, FU model returns a+b -> fu_valid next cycle, resp_valid FU_LAT+1 later with resp_id=2, resp_z=0x40400000.
REQ-034 All four valid continuously from ptr=0 -> grants 0,1,2,3,0,... one per cycle; responses ids 0,1,2,3 on consecutive cycles.
REQ-035 Drain: issue 3 ops, raise drain_req next cycle -> req_ready=0 immediately, drain_done=1 the cycle after third resp_valid; drop drain_req -> RUN, issue resumes.
REQ-036 Reset with 2 ops in flight -> outputs cleared immediately, no resp_valid after rst_n release; first post-reset grant to requester 0.
REQ-037 Requesters 1 and 3 only, ptr=2 -> grant 3 then 1; inflight returns to 0 after both responses.
